ba_burst_sched: RTL



---
 rtl/ba_burst_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ba_burst_sched.sv
// Round-robin multi-beat burst scheduler: one registered one-hot grant shared by N requesters.
// Optional macro BA_BURST_LOCK_EN adds a `lock` input that suppresses the burst-limit release.
module ba_burst_sched #(
    parameter int N         = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = $clog2(N)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   req,
    input  logic                           ack,
`ifdef BA_BURST_LOCK_EN
    input  logic                           lock,
`endif
    output logic [N-1:0]                   grant,
    output logic                           grant_valid,
    output logic [IDW-1:0]                 grant_id,
    output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt,
    output logic                           ack_err
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
    logic           ack_err_q, ack_err_d;

    logic           lock_s;
    logic           owner_req_s;
    logic           at_limit_s;
    logic           release_s;
    logic [IDW-1:0] ptr_next_s;
    logic [IDW-1:0] win_s;

`ifdef BA_BURST_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    // First set request at or after pointer p, wrapping mod N (descending scan so the nearest wins).
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] pick;
        int             j;
        pick = {IDW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(p) + i;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (r[j]) begin
                pick = IDW'(j);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= {IDW{1'b0}};
            grant_q       <= {N{1'b0}};
            grant_valid_q <= 1'b0;
            grant_id_q    <= {IDW{1'b0}};
            beat_cnt_q    <= {BW{1'b0}};
            ack_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            beat_cnt_q    <= beat_cnt_d;
            ack_err_q     <= ack_err_d;
        end
    end

    // Next-state: release detection, rotated pointer and arbitration winner.
    always_comb begin
        owner_req_s = req[grant_id_q];
        at_limit_s  = (beat_cnt_q == BW'(MAX_BURST - 1));
        release_s   = (state_q == ST_BUSY) &&
                      (!owner_req_s || (ack && at_limit_s && !lock_s));
        if (release_s) begin
            ptr_next_s = (grant_id_q == IDW'(N - 1)) ? {IDW{1'b0}} : grant_id_q + IDW'(1);
        end else begin
            ptr_next_s = ptr_q;
        end
        win_s = rr_pick(req, ptr_next_s);
        case (state_q)
            ST_IDLE: state_d = (|req) ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (release_s) begin
                    state_d = (|req) ? ST_BUSY : ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values.
    always_comb begin
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        ack_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ack_err_d  = ack;
                beat_cnt_d = {BW{1'b0}};
                if (|req) begin
                    grant_d    = N'(1) << win_s;
                    grant_id_d = win_s;
                end else begin
                    grant_d    = {N{1'b0}};
                    grant_id_d = {IDW{1'b0}};
                end
            end
            ST_BUSY: begin
                ptr_d = ptr_next_s;
                if (release_s) begin
                    beat_cnt_d = {BW{1'b0}};
                    if (|req) begin
                        grant_d    = N'(1) << win_s;
                        grant_id_d = win_s;
                    end else begin
                        grant_d    = {N{1'b0}};
                        grant_id_d = {IDW{1'b0}};
                    end
                end else if (ack && owner_req_s) begin
                    // Only reachable at the limit while locked: saturate instead of wrapping.
                    if (at_limit_s) begin
                        beat_cnt_d = beat_cnt_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                ptr_d      = {IDW{1'b0}};
                grant_d    = {N{1'b0}};
                grant_id_d = {IDW{1'b0}};
                beat_cnt_d = {BW{1'b0}};
            end
        endcase
        grant_valid_d = |grant_d;
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign beat_cnt    = beat_cnt_q;
    assign ack_err     = ack_err_q;

endmodule
